// File: rtl/fpmul_share_arbiter.sv
// rtl/fpmul_share_arbiter.sv - round-robin arbiter sharing one FP multiplier across requesters
module fpmul_share_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [32*N_REQ-1:0]   req_a_i,
  input  logic [32*N_REQ-1:0]   req_b_i,
  output logic [31:0]           mul_a_o,
  output logic [31:0]           mul_b_o,
  output logic                  mul_start_o,
  input  logic                  mul_done_i,
  input  logic                  mul_nan_i,
  input  logic                  mul_inf_i,
  input  logic                  mul_ovf_i,
  input  logic                  mul_unf_i,
  input  logic [31:0]           mul_product_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [31:0]           rsp_product_o,
  output logic [4:0]            rsp_flags_o,
  output logic                  busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic               done_q;
  logic [CNT_W-1:0]   wd_cnt;

  logic [2*N_REQ-1:0] valid_dbl;
  logic [2*N_REQ-1:0] valid_rot;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic               done_edge;

  // Rotate the valid vector so bit 0 is the requester just after last_grant;
  // the lowest set bit of the rotated vector is the round-robin winner.
  always_comb begin
    valid_dbl = {req_valid_i, req_valid_i};
    valid_rot = valid_dbl >> (int'(last_grant) + 1);
    grant_any = |req_valid_i;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) grant_idx = ID_W'((int'(last_grant) + 1 + i) % N_REQ);
    end
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_a = req_a_i[32*k +: 32];
        sel_b = req_b_i[32*k +: 32];
      end
    end
  end

  assign req_ready_o = (rst_n && state == IDLE && grant_any)
                     ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign done_edge   = mul_done_i & ~done_q;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= ID_W'(N_REQ - 1);
      done_q        <= 1'b0;
      wd_cnt        <= '0;
      mul_a_o       <= '0;
      mul_b_o       <= '0;
      mul_start_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_id_o      <= '0;
      rsp_product_o <= '0;
      rsp_flags_o   <= '0;
    end else begin
      done_q <= mul_done_i;
      case (state)
        IDLE: begin
          if (grant_any) begin
            mul_a_o     <= sel_a;
            mul_b_o     <= sel_b;
            rsp_id_o    <= grant_idx;
            last_grant  <= grant_idx;
            mul_start_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start_o <= 1'b0;
          wd_cnt      <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          // A fresh done edge takes precedence over a watchdog expiry in the same cycle.
          if (done_edge) begin
            rsp_product_o <= mul_product_i;
            rsp_flags_o   <= {1'b0, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i};
            rsp_valid_o   <= 1'b1;
            state         <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && wd_cnt == TO_LAST) begin
            rsp_product_o <= 32'h7FC0_0000;
            rsp_flags_o   <= 5'b10000;
            rsp_valid_o   <= 1'b1;
            state         <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_share_arbiter.sv
// tb/tb_fpmul_share_arbiter.sv - directed bench for the shared FP multiplier arbiter
module tb_fpmul_share_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [32*N-1:0] req_a_i = '0;
  logic [32*N-1:0] req_b_i = '0;
  logic [31:0]    mul_a_o, mul_b_o;
  logic           mul_start_o;
  logic           mul_done_i = 1'b0;
  logic           mul_nan_i = 1'b0, mul_inf_i = 1'b0, mul_ovf_i = 1'b0, mul_unf_i = 1'b0;
  logic [31:0]    mul_product_i = '0;
  logic           rsp_valid_o;
  logic           rsp_ready_i = 1'b0;
  logic [1:0]     rsp_id_o;
  logic [31:0]    rsp_product_o;
  logic [4:0]     rsp_flags_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  fpmul_share_arbiter #(.N_REQ(N), .ID_W(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_start_o(mul_start_o),
    .mul_done_i(mul_done_i), .mul_nan_i(mul_nan_i), .mul_inf_i(mul_inf_i),
    .mul_ovf_i(mul_ovf_i), .mul_unf_i(mul_unf_i), .mul_product_i(mul_product_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_product_o(rsp_product_o), .rsp_flags_o(rsp_flags_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input logic [3:0] valid, input int id, input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < N; k++) begin
      req_a_i[32*k +: 32] = (k == id) ? a : ~a;
      req_b_i[32*k +: 32] = (k == id) ? b : ~b;
    end
    req_valid_i = valid;
  endtask

  // Called in an IDLE cycle with requests already driven; ends in the first WAIT cycle.
  task automatic accept(input int id, input logic [31:0] a, input logic [31:0] b);
    logic [3:0] exp_oh;
    exp_oh = '0;
    exp_oh[id] = 1'b1;
    #1;
    check("req_ready_grant", req_ready_o, exp_oh);
    cyc();
    check("issue_start", {mul_start_o, busy_o, req_ready_o}, {1'b1, 1'b1, 4'b0000});
    check("issue_operands", {mul_a_o, mul_b_o}, {a, b});
    req_valid_i = '0;
    cyc();
    check("wait_start_low", {mul_start_o, mul_a_o}, {1'b0, a});
  endtask

  task automatic request(input logic [3:0] valid, input int id, input logic [31:0] a, input logic [31:0] b);
    drive_req(valid, id, a, b);
    accept(id, a, b);
  endtask

  task automatic serve(input int lat, input logic [31:0] prod, input logic [3:0] flg, input bit keep);
    check("no_early_rsp", rsp_valid_o, 1'b0);
    for (int i = 0; i < lat; i++) cyc();
    mul_product_i = prod;
    {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} = flg;
    mul_done_i = 1'b1;
    cyc();
    if (!keep) mul_done_i = 1'b0;
  endtask

  task automatic finish_rsp(input int id, input logic [31:0] prod, input logic [4:0] flg);
    check("rsp_valid", rsp_valid_o, 1'b1);
    check("rsp_id", rsp_id_o, id[1:0]);
    check("rsp_product", rsp_product_o, prod);
    check("rsp_flags", rsp_flags_o, flg);
    rsp_ready_i = 1'b1;
    cyc();
    check("rsp_done", {rsp_valid_o, busy_o}, 2'b00);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL bench_watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  bad;

    vt[0] = '{4'b1111, 0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 4'b0000, 0};
    vt[1] = '{4'b1110, 1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 1};
    vt[2] = '{4'b1100, 2, 32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 4'b0000, 2};
    vt[3] = '{4'b1000, 3, 32'hC000_0000, 32'h4000_0000, 32'hC080_0000, 4'b0000, 3};
    vt[4] = '{4'b0101, 0, 32'h1111_0000, 32'h2222_0000, 32'h0000_0A00, 4'b0001, 1};
    vt[5] = '{4'b0101, 2, 32'h3333_0000, 32'h4444_0000, 32'h0000_0B00, 4'b0010, 0};
    vt[6] = '{4'b0101, 0, 32'h5555_0000, 32'h6666_0000, 32'h0000_0C00, 4'b0100, 2};
    vt[7] = '{4'b0101, 2, 32'h7777_0000, 32'h0888_0000, 32'h0000_0D00, 4'b0000, 1};
    vt[8] = '{4'b0001, 0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 2};
    vt[9] = '{4'b0010, 1, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1};

    req_valid_i = 4'b1111;
    cyc();
    cyc();
    check("reset_ctrl", {busy_o, mul_start_o, rsp_valid_o, req_ready_o}, 7'b0);
    check("reset_data", {mul_a_o, mul_b_o}, 64'h0);
    check("reset_rsp", {rsp_id_o, rsp_product_o, rsp_flags_o}, 39'h0);
    rst_n = 1'b1;
    req_valid_i = '0;
    cyc();

    for (int i = 0; i < 10; i++) begin
      request(vt[i].valid, vt[i].id, vt[i].a, vt[i].b);
      serve(vt[i].lat, vt[i].prod, vt[i].flg, 1'b0);
      finish_rsp(vt[i].id, vt[i].prod, {1'b0, vt[i].flg});
    end

    // Backpressure: response held for 10 cycles while requester 0 waits.
    request(4'b0100, 2, 32'h4100_0000, 32'h4100_0000);
    serve(0, 32'h4280_0000, 4'b0000, 1'b0);
    drive_req(4'b0001, 0, 32'h3F00_0000, 32'h4000_0000);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_hold", {rsp_valid_o, rsp_id_o, rsp_product_o, req_ready_o},
            {1'b1, 2'd2, 32'h4280_0000, 4'b0000});
      cyc();
    end
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
    check("bp_released", rsp_valid_o, 1'b0);
    accept(0, 32'h3F00_0000, 32'h4000_0000);
    serve(1, 32'h3F80_0000, 4'b0000, 1'b0);
    finish_rsp(0, 32'h3F80_0000, 5'b00000);

    // Stale done: the level left high by one op must not complete the next.
    request(4'b1000, 3, 32'h4000_0000, 32'h4000_0000);
    serve(1, 32'h4080_0000, 4'b0000, 1'b1);
    finish_rsp(3, 32'h4080_0000, 5'b00000);
    request(4'b0010, 1, 32'h4040_0000, 32'h4040_0000);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rsp_valid_o) bad = 1'b1;
    end
    check("stale_done_ignored", bad, 1'b0);
    mul_done_i = 1'b0;
    mul_product_i = 32'h4110_0000;
    cyc();
    mul_done_i = 1'b1;
    cyc();
    mul_done_i = 1'b0;
    finish_rsp(1, 32'h4110_0000, 5'b00000);

    // Watchdog: done never rises.
    request(4'b0001, 0, 32'h1234_5678, 32'h9ABC_DEF0);
    mul_product_i = 32'h0BAD_0BAD;
    n = 0;
    while (!rsp_valid_o && n < 100) begin
      cyc();
      n++;
    end
    check("timeout_latency", n, 64);
    finish_rsp(0, 32'h7FC0_0000, 5'b10000);

    // Asynchronous reset in the middle of WAIT.
    request(4'b0100, 2, 32'h4500_0000, 32'h4600_0000);
    drive_req(4'b1001, 0, 32'h4000_0000, 32'h4000_0000);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {busy_o, mul_start_o, rsp_valid_o, req_ready_o}, 7'b0);
    check("async_rst_data", {mul_a_o, mul_b_o}, 64'h0);
    check("async_rst_rsp", {rsp_id_o, rsp_product_o, rsp_flags_o}, 39'h0);
    cyc();
    rst_n = 1'b1;
    request(4'b1001, 0, 32'h4000_0000, 32'h4000_0000);
    serve(1, 32'h4080_0000, 4'b0000, 1'b0);
    finish_rsp(0, 32'h4080_0000, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
